// File: rtl/kbd_pkg.sv
// Shared scan-code constants and enums for the PS/2 step decoder.
// Optional arrow-key mapping is enabled by defining KBD_ARROW_KEYS_EN.
package kbd_pkg;

  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_LEFT_X  = 8'h6B;
  localparam logic [7:0] SC_RIGHT_X = 8'h74;
  localparam logic [7:0] SC_UP_X    = 8'h75;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kbd_state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_A,
    K_D,
    K_W,
    K_SPC,
    K_XL,
    K_XR,
    K_XU
  } key_id_t;

endpackage

// File: rtl/kbd_key_map.sv
// Combinational scan-code to key-id lookup; arrow entries exist only
// when KBD_ARROW_KEYS_EN is defined.
module kbd_key_map
  import kbd_pkg::*;
(
  input  logic [7:0] rx_data,
  input  logic       ext,
  output key_id_t    key
);

  always_comb begin
    key = K_NONE;
    if (!ext) begin
      case (rx_data)
        SC_A:     key = K_A;
        SC_D:     key = K_D;
        SC_W:     key = K_W;
        SC_SPACE: key = K_SPC;
        default:  key = K_NONE;
      endcase
    end else begin
`ifdef KBD_ARROW_KEYS_EN
      case (rx_data)
        SC_LEFT_X:  key = K_XL;
        SC_RIGHT_X: key = K_XR;
        SC_UP_X:    key = K_XU;
        default:    key = K_NONE;
      endcase
`else
      key = K_NONE;
`endif
    end
  end

endmodule

// File: rtl/kbd_step_decoder.sv
// PS/2 set-2 make/break decoder producing held step levels for char_ctrl.
// Define KBD_ARROW_KEYS_EN to also map the extended arrow keys.
module kbd_step_decoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_600_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  kbd_state_t    state;
  logic [CW-1:0] tmo_cnt;
  key_id_t       key;

  logic is_ext;
  logic is_brk;
  logic is_prefix_byte;
  logic key_hit;
  logic make;

  logic key_a, key_d, key_w, key_spc;
  logic a_nxt, d_nxt, w_nxt, spc_nxt;
  logic left_nxt, right_nxt, jump_nxt;

  assign is_ext         = (state == EXT) || (state == EXT_BRK);
  assign is_brk         = (state == BRK) || (state == EXT_BRK);
  assign is_prefix_byte = (rx_data == SC_EXT) || (rx_data == SC_BRK);
  assign key_hit        = rx_valid && !is_prefix_byte;
  assign make           = !is_brk;

  kbd_key_map u_key_map (
    .rx_data (rx_data),
    .ext     (is_ext),
    .key     (key)
  );

`ifdef KBD_ARROW_KEYS_EN
  logic key_xl, key_xr, key_xu;
  logic xl_nxt, xr_nxt, xu_nxt;
`endif

  always_comb begin
    a_nxt   = key_a;
    d_nxt   = key_d;
    w_nxt   = key_w;
    spc_nxt = key_spc;
`ifdef KBD_ARROW_KEYS_EN
    xl_nxt  = key_xl;
    xr_nxt  = key_xr;
    xu_nxt  = key_xu;
`endif
    if (key_hit) begin
      case (key)
        K_A:     a_nxt   = make;
        K_D:     d_nxt   = make;
        K_W:     w_nxt   = make;
        K_SPC:   spc_nxt = make;
`ifdef KBD_ARROW_KEYS_EN
        K_XL:    xl_nxt  = make;
        K_XR:    xr_nxt  = make;
        K_XU:    xu_nxt  = make;
`endif
        default: ;
      endcase
    end
  end

`ifdef KBD_ARROW_KEYS_EN
  assign left_nxt  = a_nxt | xl_nxt;
  assign right_nxt = d_nxt | xr_nxt;
  assign jump_nxt  = w_nxt | spc_nxt | xu_nxt;
`else
  assign left_nxt  = a_nxt;
  assign right_nxt = d_nxt;
  assign jump_nxt  = w_nxt | spc_nxt;
`endif

  // Prefix FSM; a received byte always wins over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else if (clear) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else if (rx_valid) begin
      tmo_cnt <= '0;
      case (state)
        IDLE: begin
          if (rx_data == SC_EXT)      state <= EXT;
          else if (rx_data == SC_BRK) state <= BRK;
          else                        state <= IDLE;
        end
        EXT: begin
          if (rx_data == SC_BRK)      state <= EXT_BRK;
          else if (rx_data == SC_EXT) state <= EXT;
          else                        state <= IDLE;
        end
        BRK: begin
          if (rx_data == SC_EXT)      state <= EXT_BRK;
          else if (rx_data == SC_BRK) state <= BRK;
          else                        state <= IDLE;
        end
        EXT_BRK: begin
          if (is_prefix_byte) state <= EXT_BRK;
          else                state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tmo_cnt == CNT_LAST) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Pressed bits and resolved outputs update together so outputs lag a byte by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_a     <= 1'b0;
      key_d     <= 1'b0;
      key_w     <= 1'b0;
      key_spc   <= 1'b0;
      stepleft  <= 1'b0;
      stepright <= 1'b0;
      stepjump  <= 1'b0;
    end else if (clear) begin
      key_a     <= 1'b0;
      key_d     <= 1'b0;
      key_w     <= 1'b0;
      key_spc   <= 1'b0;
      stepleft  <= 1'b0;
      stepright <= 1'b0;
      stepjump  <= 1'b0;
    end else begin
      key_a     <= a_nxt;
      key_d     <= d_nxt;
      key_w     <= w_nxt;
      key_spc   <= spc_nxt;
      stepleft  <= left_nxt & ~right_nxt;
      stepright <= right_nxt & ~left_nxt;
      stepjump  <= jump_nxt;
    end
  end

`ifdef KBD_ARROW_KEYS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_xl <= 1'b0;
      key_xr <= 1'b0;
      key_xu <= 1'b0;
    end else if (clear) begin
      key_xl <= 1'b0;
      key_xr <= 1'b0;
      key_xu <= 1'b0;
    end else begin
      key_xl <= xl_nxt;
      key_xr <= xr_nxt;
      key_xu <= xu_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_kbd_step_decoder.sv
// Bench for kbd_step_decoder: directed steps then random byte stream
// against a held-key reference model; honours KBD_ARROW_KEYS_EN.
module tb_kbd_step_decoder;

  localparam int T = 16;
`ifdef KBD_ARROW_KEYS_EN
  localparam bit ARROWS = 1'b1;
`else
  localparam bit ARROWS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clear = 1'b0;
  logic       stepleft, stepright, stepjump;

  always #5 clk = ~clk;

  kbd_step_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .clear     (clear),
    .stepleft  (stepleft),
    .stepright (stepright),
    .stepjump  (stepjump)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: held state per (extended?, code), plus pending prefix flags.
  bit held_p [256];
  bit held_x [256];
  bit m_ext, m_brk;
  int gap;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      held_p[i] = 1'b0;
      held_x[i] = 1'b0;
    end
    m_ext = 1'b0;
    m_brk = 1'b0;
    gap   = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    gap = 0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_ext) held_x[b] = !m_brk;
      else       held_p[b] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_idle();
    if (m_ext || m_brk) begin
      gap++;
      if (gap >= T) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
        gap   = 0;
      end
    end
  endfunction

  function automatic bit exp_l();
    return held_p[8'h1C] | (ARROWS & held_x[8'h6B]);
  endfunction
  function automatic bit exp_r();
    return held_p[8'h23] | (ARROWS & held_x[8'h74]);
  endfunction
  function automatic bit exp_j();
    return held_p[8'h1D] | held_p[8'h29] | (ARROWS & held_x[8'h75]);
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    bit l, r, j;
    l = exp_l();
    r = exp_r();
    j = exp_j();
    check_bit({tag, ".stepleft"},  stepleft,  l & ~r);
    check_bit({tag, ".stepright"}, stepright, r & ~l);
    check_bit({tag, ".stepjump"},  stepjump,  j);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b);
    check_outs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      model_idle();
    end
    check_outs(tag);
  endtask

  task automatic clear_with_byte(input logic [7:0] b, input string tag);
    rx_data  = b;
    rx_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    clear    = 1'b0;
    model_reset();
    check_outs(tag);
  endtask

  logic [7:0] pool [13] = '{8'h1C, 8'h23, 8'h1D, 8'h29, 8'h6B, 8'h74, 8'h75,
                            8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'hE1, 8'h12};

  initial begin
    // Reset with bytes being strobed in
    model_reset();
    rx_data  = 8'h1C;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_outs("reset_hold");
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_outs("reset_release");

    // Single make appears one cycle after strobe
    send(8'h1C, "make_a");
    send(8'hF0, "brk_prefix_a");
    send(8'h1C, "break_a");

    // Press, typematic repeats, release
    send(8'h23, "make_d");
    for (int i = 0; i < 5; i++) send(8'h23, "repeat_d");
    send(8'hF0, "brk_prefix_d");
    send(8'h23, "break_d");

    // Opposition
    send(8'h1C, "opp_left");
    send(8'h23, "opp_both");
    send(8'hF0, "opp_brk");
    send(8'h1C, "opp_right_only");
    send(8'hF0, "opp_rel_brk");
    send(8'h23, "opp_rel_d");

    // Jump OR of W and SPACE
    send(8'h1D, "jump_w");
    send(8'h29, "jump_spc");
    send(8'hF0, "jump_brk_w0");
    send(8'h1D, "jump_rel_w");
    send(8'hF0, "jump_brk_s0");
    send(8'h29, "jump_rel_spc");

    // Timeout abandons a pending break; a short gap does not
    send(8'hF0, "tmo_prefix");
    idle(T + 2, "tmo_wait");
    send(8'h1C, "tmo_make");
    send(8'hF0, "short_prefix");
    idle(T - 4, "short_wait");
    send(8'h1C, "short_break");

    // Clear outranks a coincident byte
    send(8'h1C, "clr_hold");
    send(8'h1D, "clr_hold_j");
    clear_with_byte(8'hF0, "clear");
    send(8'h1C, "post_clear_make");
    send(8'hF0, "post_clear_brk");
    send(8'h1C, "post_clear_rel");

    // Extended codes
    send(8'hE0, "arrow_ext");
    send(8'h6B, "arrow_left");
    send(8'hE0, "arrow_rel_e0");
    send(8'hF0, "arrow_rel_f0");
    send(8'h6B, "arrow_rel");
    send(8'hE0, "xplain_e0");
    send(8'h1C, "xplain_1c");
    send(8'h1D, "after_ext_jump");
    send(8'hE0, "xbrk_e0_first");
    send(8'hF0, "xbrk_f0");
    send(8'h1D, "xbrk_w_ext");
    send(8'hF0, "bf_e0_f0");
    send(8'hE0, "bf_e0_e0");
    send(8'h75, "bf_up_break");

    // Async reset mid-sequence discards the prefix
    send(8'hF0, "rst_mid_prefix");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h23, "rst_mid_make");

    // Random stream
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 2) clear_with_byte(pool[$urandom_range(0, 12)], "rnd_clear");
      else if (sel < 5) idle(T + 5, "rnd_long_idle");
      else if (sel < 25) idle($urandom_range(1, 3), "rnd_idle");
      else send(pool[$urandom_range(0, 12)], "rnd_byte");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
